// File: rtl/branch_0_layer_1_maxpool2d_pkg.sv
// Shared types and helpers for the branch-0 layer-1 2x2/stride-2 max-pool stage.
package pool_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_CH    = 4;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam int LBUF_DEPTH = (DEF_IMG_W / 2) * DEF_CH;
  localparam int LBUF_AW    = $clog2(LBUF_DEPTH);

  // Address width for an arbitrary line-buffer depth (at least one bit).
  function automatic int lbuf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Max of two activations; ties return the shared value, no width growth.
  function automatic pixel_t pix_max(input pixel_t a, input pixel_t b, input logic is_signed);
    pixel_t m;
    if (is_signed) begin
      m = ($signed(a) > $signed(b)) ? a : b;
    end else begin
      m = (a > b) ? a : b;
    end
    return m;
  endfunction

endpackage

// File: rtl/branch_0_layer_1_maxpool2d_line_buf.sv
// Half-width line buffer holding even-row horizontal maxima: 1 write port, 1 async read port, no reset.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = LBUF_DEPTH,
  parameter int AW    = LBUF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem_r [DEPTH];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/branch_0_layer_1_maxpool2d.sv
// Streaming 2x2/stride-2 max-pool over an HWC activation stream with a 1-deep output register.
// Optional macro MAXPOOL_FUSED_RELU_EN clamps negative results to zero when SIGNED_DATA=1.
module branch_0_layer_1_maxpool2d
  import pool_pkg::*;
#(
  parameter int IN0_DATA_WIDTH  = 8,
  parameter int OUT0_DATA_WIDTH = 8,
  parameter int IMG_W           = 32,
  parameter int IMG_H           = 32,
  parameter int CH              = 4,
  parameter int SIGNED_DATA     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN0_DATA_WIDTH-1:0]  din_rsc_dat,
  input  logic                       din_rsc_vld,
  output logic                       din_rsc_rdy,
  output logic [OUT0_DATA_WIDTH-1:0] dout_rsc_dat,
  output logic                       dout_rsc_vld,
  input  logic                       dout_rsc_rdy
);

  localparam int   LB_DEPTH  = (IMG_W / 2) * CH;
  localparam int   LB_AW     = lbuf_aw(LB_DEPTH);
  localparam int   CW        = (CH > 1) ? $clog2(CH) : 1;
  localparam int   XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int   YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic IS_SIGNED = (SIGNED_DATA != 0);

  generate
    if (OUT0_DATA_WIDTH != IN0_DATA_WIDTH) begin : g_bad_out_width
      $error("OUT0_DATA_WIDTH must equal IN0_DATA_WIDTH");
    end
    if (IN0_DATA_WIDTH != PIX_W) begin : g_bad_pix_width
      $error("IN0_DATA_WIDTH must match pool_pkg::PIX_W");
    end
    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_bad_geometry
      $error("IMG_W and IMG_H must be even");
    end
  endgenerate

  logic [CW-1:0]    ch_r, ch_nxt_s;
  logic [XW-1:0]    col_r, col_nxt_s;
  logic [YW-1:0]    row_r, row_nxt_s;
  pixel_t           hreg_r [CH];
  pixel_t           dout_dat_r;
  logic             dout_vld_r;

  logic             din_rdy_s;
  logic             accept_s;
  logic             lb_we_s;
  logic             out_load_s;
  logic [LB_AW-1:0] lb_addr_s;
  pixel_t           px_s;
  pixel_t           lb_rdata_s;
  pixel_t           hmax_s;
  pixel_t           raw_max_s;
  pixel_t           result_s;

  // Ready passes through the output register: free slot or the slot drains this cycle.
  assign din_rdy_s  = !rst && (!dout_vld_r || dout_rsc_rdy);
  assign accept_s   = din_rsc_vld && din_rdy_s;
  assign px_s       = din_rsc_dat;
  assign lb_we_s    = accept_s && !row_r[0] && col_r[0];
  assign out_load_s = accept_s && row_r[0] && col_r[0];

  // Channel/column/row position of the next beat, wrapping at end of frame.
  always_comb begin
    ch_nxt_s  = ch_r;
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    if (accept_s) begin
      if (ch_r == CW'(CH - 1)) begin
        ch_nxt_s = {CW{1'b0}};
        if (col_r == XW'(IMG_W - 1)) begin
          col_nxt_s = {XW{1'b0}};
          if (row_r == YW'(IMG_H - 1)) begin
            row_nxt_s = {YW{1'b0}};
          end else begin
            row_nxt_s = row_r + YW'(1);
          end
        end else begin
          col_nxt_s = col_r + XW'(1);
        end
      end else begin
        ch_nxt_s = ch_r + CW'(1);
      end
    end else begin
      ch_nxt_s  = ch_r;
      col_nxt_s = col_r;
      row_nxt_s = row_r;
    end
  end

  // Window datapath; the same line-buffer slot is written on even rows and read on odd rows.
  always_comb begin
    lb_addr_s = LB_AW'((32'(col_r) >> 1) * 32'(CH) + 32'(ch_r));
    hmax_s    = pix_max(hreg_r[ch_r], px_s, IS_SIGNED);
    raw_max_s = pix_max(hmax_s, lb_rdata_s, IS_SIGNED);
`ifdef MAXPOOL_FUSED_RELU_EN
    if (IS_SIGNED && raw_max_s[PIX_W-1]) begin
      result_s = {PIX_W{1'b0}};
    end else begin
      result_s = raw_max_s;
    end
`else
    result_s = raw_max_s;
`endif
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we_s),
    .waddr (lb_addr_s),
    .wdata (hmax_s),
    .raddr (lb_addr_s),
    .rdata (lb_rdata_s)
  );

  // Position counters and output register; a new result may replace one leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r       <= {CW{1'b0}};
      col_r      <= {XW{1'b0}};
      row_r      <= {YW{1'b0}};
      dout_vld_r <= 1'b0;
      dout_dat_r <= {PIX_W{1'b0}};
    end else begin
      ch_r  <= ch_nxt_s;
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
      if (out_load_s) begin
        dout_vld_r <= 1'b1;
        dout_dat_r <= result_s;
      end else if (dout_rsc_rdy) begin
        dout_vld_r <= 1'b0;
      end
    end
  end

  // Even-column pixels held per channel until their odd-column partner arrives.
  always_ff @(posedge clk) begin
    if (accept_s && !col_r[0]) begin
      hreg_r[ch_r] <= px_s;
    end
  end

  assign din_rsc_rdy  = din_rdy_s;
  assign dout_rsc_dat = dout_dat_r;
  assign dout_rsc_vld = dout_vld_r;

endmodule
